// File: rtl/mem_defs.sv
// Shared memory-cluster definitions: store-queue IDs/pointers, drain FSM states,
// per-entry allocation state, nuke packet and the circular ROB age compare.
package mem_defs;

    localparam int unsigned STQ_NUM_ENTRIES = 8;
    localparam int unsigned STQ_ID_W        = $clog2(STQ_NUM_ENTRIES);
    localparam int unsigned ROB_ID_W        = 6;

    typedef logic [ROB_ID_W-1:0] t_rob_id;
    typedef logic [STQ_ID_W-1:0] t_stq_id;
    typedef logic [STQ_ID_W:0]   t_stq_ptr;

    typedef enum logic [1:0] {
        DR_IDLE = 2'd0,
        DR_REQ  = 2'd1,
        DR_WAIT = 2'd2
    } t_stq_drain_state;

    typedef struct packed {
        logic    valid;
        t_rob_id robid;
        logic    issued;
        logic    senior;
    } t_stq_alloc_entry;

    typedef struct packed {
        logic    valid;
        t_rob_id robid;
    } t_nuke_pkt;

    // True when a is the same age as or younger than b, ages taken relative to oldest.
    function automatic logic rob_younger_eq(input t_rob_id a, input t_rob_id b,
                                            input t_rob_id oldest);
        t_rob_id age_a;
        t_rob_id age_b;
        age_a = a - oldest;
        age_b = b - oldest;
        return age_a >= age_b;
    endfunction

endpackage

// File: rtl/stq_alloc_ctl_entry.sv
// One store-queue allocation entry: valid/issued/senior tracking and its own
// nuke flush decision.
module stq_alloc_ctl_entry
    import mem_defs::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_alloc,
    input  t_rob_id   i_alloc_robid,
    input  logic      i_issue,
    input  logic      i_clear,
    input  t_rob_id   i_oldest_robid,
    input  t_nuke_pkt i_nuke,
    output logic      o_valid,
    output logic      o_senior,
    output logic      o_flush_c
);

    t_stq_alloc_entry r_ent;
    logic             w_senior_set;

    assign w_senior_set = r_ent.valid & r_ent.issued & (r_ent.robid == i_oldest_robid);

    // An entry becoming senior this cycle is already committed and must survive.
    assign o_flush_c = i_nuke.valid & r_ent.valid & ~r_ent.senior & ~w_senior_set
                     & rob_younger_eq(r_ent.robid, i_nuke.robid, i_oldest_robid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ent <= '0;
        end else if (i_clear || o_flush_c) begin
            r_ent <= '0;
        end else if (i_alloc) begin
            r_ent <= '{valid: 1'b1, robid: i_alloc_robid, issued: 1'b0, senior: 1'b0};
        end else begin
            if (i_issue) begin
                r_ent.issued <= 1'b1;
            end
            if (w_senior_set) begin
                r_ent.senior <= 1'b1;
            end
        end
    end

    assign o_valid  = r_ent.valid;
    assign o_senior = r_ent.senior;

endmodule

// File: rtl/stq_alloc_ctl.sv
// Store-queue allocation and drain controller: in-order ID allocation, nuke tail
// rollback and one-at-a-time senior store drain. Perf counters under STQ_ALLOC_PERF_EN.
module stq_alloc_ctl
    import mem_defs::*;
#(
    parameter int unsigned NUM_ENTRIES = STQ_NUM_ENTRIES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        disp_valid_rs0,
    input  logic        disp_is_st_rs0,
    input  t_rob_id     disp_robid_rs0,
    output logic        stq_alloc_ok_rs0,
    output t_stq_id     stq_alloc_id_rs0,
    input  logic        iss_st_mm0,
    input  t_stq_id     iss_stqid_mm0,
    input  t_nuke_pkt   nuke_rb1,
    input  t_rob_id     oldest_robid,
    output logic        drain_req,
    output t_stq_id     drain_stqid,
    input  logic        drain_gnt,
    input  logic        drain_done,
    output logic [31:0] perf_full_stall_cnt,
    output logic [31:0] perf_nuke_flush_cnt
);

    localparam int unsigned ID_W  = $clog2(NUM_ENTRIES);
    localparam int unsigned PTR_W = ID_W + 1;
    localparam int unsigned CNT_W = ID_W + 1;

    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [PTR_W-1:0]       w_head_nxt;
    logic [PTR_W-1:0]       w_tail_nxt;
    logic [PTR_W-1:0]       w_count;
    logic [ID_W-1:0]        w_head_id;
    logic [ID_W-1:0]        w_tail_id;
    logic                   w_full;
    logic                   w_alloc;
    logic                   w_free;
    logic [CNT_W-1:0]       w_surv_cnt;
    t_stq_drain_state       r_state;
    t_stq_drain_state       w_state_nxt;
    logic                   r_drain_req;

    logic [NUM_ENTRIES-1:0] w_ent_valid;
    logic [NUM_ENTRIES-1:0] w_ent_senior;
    logic [NUM_ENTRIES-1:0] w_flush;
    logic [NUM_ENTRIES-1:0] w_clear;

    assign w_head_id        = r_head[ID_W-1:0];
    assign w_tail_id        = r_tail[ID_W-1:0];
    assign w_count          = r_tail - r_head;
    assign w_full           = (w_count == PTR_W'(NUM_ENTRIES));
    assign w_alloc          = disp_valid_rs0 & disp_is_st_rs0 & ~w_full & ~nuke_rb1.valid;
    assign stq_alloc_ok_rs0 = ~w_full;
    assign stq_alloc_id_rs0 = t_stq_id'(w_tail_id);
    assign drain_req        = r_drain_req;
    assign drain_stqid      = t_stq_id'(w_head_id);

    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_ent
        assign w_clear[gi] = w_free & (w_head_id == ID_W'(gi));

        stq_alloc_ctl_entry u_ent (
            .clk            (clk),
            .reset          (reset),
            .i_alloc        (w_alloc & (w_tail_id == ID_W'(gi))),
            .i_alloc_robid  (disp_robid_rs0),
            .i_issue        (iss_st_mm0 & (iss_stqid_mm0 == ID_W'(gi))),
            .i_clear        (w_clear[gi]),
            .i_oldest_robid (oldest_robid),
            .i_nuke         (nuke_rb1),
            .o_valid        (w_ent_valid[gi]),
            .o_senior       (w_ent_senior[gi]),
            .o_flush_c      (w_flush[gi])
        );
    end

    // Survivors exclude both flushed entries and a head freed this cycle.
    always_comb begin
        w_surv_cnt = '0;
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            w_surv_cnt = w_surv_cnt + CNT_W'(w_ent_valid[i] & ~w_flush[i] & ~w_clear[i]);
        end
    end

    assign w_head_nxt = r_head + PTR_W'(w_free);
    assign w_tail_nxt = nuke_rb1.valid ? (w_head_nxt + PTR_W'(w_surv_cnt))
                                       : (r_tail + PTR_W'(w_alloc));

    // Drain FSM next state; the freeing pulse is only honoured in DR_WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_free      = 1'b0;
        case (r_state)
            DR_IDLE: begin
                if (w_ent_valid[w_head_id] && w_ent_senior[w_head_id]) begin
                    w_state_nxt = DR_REQ;
                end
            end
            DR_REQ: begin
                if (drain_gnt) begin
                    w_state_nxt = DR_WAIT;
                end
            end
            DR_WAIT: begin
                if (drain_done) begin
                    w_free      = 1'b1;
                    w_state_nxt = DR_IDLE;
                end
            end
            default: begin
                w_state_nxt = DR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= DR_IDLE;
            r_drain_req <= 1'b0;
            r_head      <= '0;
            r_tail      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_req <= (w_state_nxt == DR_REQ);
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
        end
    end

`ifdef STQ_ALLOC_PERF_EN
    logic             w_stall;
    logic [CNT_W-1:0] w_flush_cnt;
    logic [32:0]      w_nuke_sum;
    logic [31:0]      r_full_stall_cnt;
    logic [31:0]      r_nuke_flush_cnt;

    assign w_stall = disp_valid_rs0 & disp_is_st_rs0 & w_full;

    always_comb begin
        w_flush_cnt = '0;
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            w_flush_cnt = w_flush_cnt + CNT_W'(w_flush[i]);
        end
    end

    assign w_nuke_sum = {1'b0, r_nuke_flush_cnt} + 33'(w_flush_cnt);

    // Both counters saturate at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full_stall_cnt <= '0;
            r_nuke_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_full_stall_cnt != '1)) begin
                r_full_stall_cnt <= r_full_stall_cnt + 32'd1;
            end
            r_nuke_flush_cnt <= w_nuke_sum[32] ? '1 : w_nuke_sum[31:0];
        end
    end

    assign perf_full_stall_cnt = r_full_stall_cnt;
    assign perf_nuke_flush_cnt = r_nuke_flush_cnt;
`else
    assign perf_full_stall_cnt = '0;
    assign perf_nuke_flush_cnt = '0;
`endif

endmodule

// File: doc/stq_alloc_ctl.md
# stq_alloc_ctl

Store-queue allocation and drain controller for the memory cluster. It hands out store-queue IDs in program order at dispatch (rs0), which later travel with the store as `meta.mem.stqid`. It tracks issue and commit of each allocated store and drains committed (senior) stores one at a time from the queue head. It also rolls the allocation tail back on a pipeline nuke.

## Interface
Parameters:
- `NUM_ENTRIES`, default `STQ_NUM_ENTRIES` (8): queue depth, power of two.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset; all state clears while low.
- `disp_valid_rs0`  in  1  uop dispatched this cycle.
- `disp_is_st_rs0`  in  1  dispatched uop is a store.
- `disp_robid_rs0`  in  `t_rob_id`  ROB ID of the dispatched uop.
- `stq_alloc_ok_rs0`  out  1  a free entry exists; dispatch stalls stores when 0.
- `stq_alloc_id_rs0`  out  `t_stq_id`  ID given to a store dispatched this cycle.
- `iss_st_mm0`  in  1  a store issued to the store queue.
- `iss_stqid_mm0`  in  `t_stq_id`  ID of the issued store.
- `nuke_rb1`  in  `t_nuke_pkt`  flush request, using `.valid` and `.robid`.
- `oldest_robid`  in  `t_rob_id`  oldest uncommitted ROB ID.
- `drain_req`  out  1  head store requests writeback.
- `drain_stqid`  out  `t_stq_id`  head ID being drained.
- `drain_gnt`  in  1  drain request accepted.
- `drain_done`  in  1  pulse: head store written; frees the entry.
- `perf_full_stall_cnt`  out  32  cycles in which a store dispatch was blocked by full.
- `perf_nuke_flush_cnt`  out  32  entries discarded by nukes.

## Operation
- **Pointers.** `head` and `tail` are `t_stq_ptr`: the ID plus a wrap bit.
  - `count = tail - head`, modulo `2*NUM_ENTRIES`.
  - Full when `count == NUM_ENTRIES`.
- **Allocate.**
  - Condition: `disp_valid_rs0 & disp_is_st_rs0 & stq_alloc_ok_rs0 & ~nuke_rb1.valid`.
  - Effect: the entry at `tail` becomes valid with `robid = disp_robid_rs0`, `issued = 0`, `senior = 0`; `tail` increments.
- **Issue.** `iss_st_mm0` sets `issued` on entry `iss_stqid_mm0`. Issue to an invalid entry is illegal.
- **Senior.**
  - The sticky `senior` bit sets when `valid & issued & robid == oldest_robid`.
  - Senior entries are never flushed.
- **Nuke.**
  - `nuke_rb1.valid` flushes every valid, non-senior entry whose robid equals `nuke_rb1.robid` or is younger than it. Age is decided by the shared ROB age compare.
  - Surviving entries form a prefix from `head`. The new `tail` is `head` plus the number of survivors.
  - The perf counter adds the number of flushed entries.
- **Drain FSM** (`t_stq_drain_state`):
  - `DR_IDLE`: go to `DR_REQ` when the head entry is valid and senior.
  - `DR_REQ`: `drain_req = 1`, `drain_stqid = head`; go to `DR_WAIT` on `drain_gnt`.
  - `DR_WAIT`: on `drain_done`, clear the head entry, increment `head`, and return to `DR_IDLE`.
  - A `drain_done` outside `DR_WAIT` is illegal.
  - A nuke in `DR_REQ` or `DR_WAIT` does not affect the drain, because the head entry is senior.
- **Simultaneous events:**
  - Allocate and free in the same cycle: `count` is unchanged.
  - Nuke together with a free: the nuke survivor count is computed after removing the head.
  - Allocate during a nuke is dropped.

## Timing
- `stq_alloc_ok_rs0` and `stq_alloc_id_rs0` are combinational from registered `count` and `tail`.
  - There is no same-cycle bypass of a free: a full queue freed in cycle N reports `alloc_ok = 1` in cycle N+1.
- Issue affects `senior` the next cycle.
- Minimum latency from `senior` set to `drain_req`: 1 cycle (registered FSM). `drain_req` may be held indefinitely until `drain_gnt`.
- Tail rollback takes effect the cycle after `nuke_rb1.valid`.
- Reset values while `reset` is low:
  - `head = tail = 0`, all entries invalid.
  - FSM in `DR_IDLE`.
  - `stq_alloc_ok_rs0 = 1`, `stq_alloc_id_rs0 = 0`.
  - `drain_req = 0`, `drain_stqid = 0`.
  - Perf counters 0.
- Reset asserted mid-drain abandons the drain immediately.

## Configuration
- `STQ_ALLOC_PERF_EN`
  - Defined: both perf counters are implemented. They are 32-bit saturating, incrementing as described above.
  - Undefined: no counter flops; both outputs are tied to 0.

## Structure
- Shared package `mem_defs` holds:
  - `STQ_NUM_ENTRIES`, `t_stq_id`, `t_stq_ptr`.
  - `t_stq_drain_state` (enum `DR_IDLE`, `DR_REQ`, `DR_WAIT`).
  - `t_stq_alloc_entry` (`valid`, `robid`, `issued`, `senior`).
- Per-entry state lives in the sub-module `stq_alloc_ctl_entry`, instantiated `NUM_ENTRIES` times. It owns the valid/issued/senior update and outputs its own flush decision.
- Pointer, count, FSM and perf logic sit in the top module.

## Test plan
- **Fill:** from reset, 9 consecutive store dispatches with robids 0..8 -> IDs 0..7 granted; `alloc_ok = 0` on the 9th dispatch; `perf_full_stall_cnt = 1` with the macro defined.
- **Drain:** allocate ID 0 with robid 3, issue it, then set `oldest_robid = 3` -> `drain_req`, `drain_stqid = 0` two cycles later; `drain_gnt`, then `drain_done` -> `count = 0` next cycle.
- **Nuke rollback:** allocate robids 4..9 at IDs 0..5, then nuke robid 7 -> `tail = 3`; the next store gets ID 3; `perf_nuke_flush_cnt = 3`.
- **Wrap:** 8 allocations, 8 drains, then one more allocation -> ID 0 with the wrap bit set; `alloc_ok = 1`; `count = 1`.
- **Simultaneous allocate and free:** `count = 5`, allocate in the same cycle as `drain_done` -> `count = 5`, `head` and `tail` each +1.
- **Reset mid-drain:** pull `reset` low in `DR_WAIT` -> `drain_req = 0` and `alloc_ok = 1` immediately; after release, the first allocation gets ID 0.
